// File: rtl/dma_burst_writer.sv
// Ping-pong buffered packer: 128-bit packets of up to 8 words
// replayed as fixed 8-beat Avalon-MM write bursts.
module dma_burst_writer (
  input  logic         c,
  input  logic         rst,
  input  logic [127:0] d,
  input  logic         dv,
  input  logic         de,
  input  logic [22:0]  daddr,
  output logic         ready,
  output logic         txs_write,
  output logic [127:0] txs_writedata,
  output logic [5:0]   txs_burstcount,
  output logic [22:0]  txs_address,
  input  logic         txs_waitrequest
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [127:0] r_mem [2][8];
  logic [22:0]  r_addr [2];
  logic [1:0]   r_busy;
  logic [1:0]   r_pend;
  logic         r_wr;
  logic         r_rd;
  logic         r_cap;
  logic         r_ready;
  logic [2:0]   r_wbeat;
  logic [2:0]   r_rbeat;

  logic         w_start;
  logic         w_take;
  logic         w_close;
  logic         w_acc;
  logic         w_done;
  logic         w_issue;
  logic         w_cap_n;
  logic         w_wr_n;
  logic [2:0]   w_widx;
  logic [1:0]   w_busy_n;
  logic [1:0]   w_pend_n;

  // Slots fill and drain in strict alternation, so r_rd is always the oldest.
  assign w_start = dv & r_ready & ~r_cap;
  assign w_take  = w_start | (dv & r_cap);
  assign w_widx  = w_start ? 3'd0 : r_wbeat;
  assign w_close = w_take & (de | (w_widx == 3'd7));
  assign w_acc   = (r_state == S_BURST) & ~txs_waitrequest;
  assign w_done  = w_acc & (r_rbeat == 3'd7);
  assign w_issue = (r_state == S_IDLE) & r_pend[r_rd];
  assign w_cap_n = (r_cap | w_start) & ~w_close;
  assign w_wr_n  = r_wr ^ w_close;

  always_comb begin
    w_busy_n = r_busy;
    w_pend_n = r_pend;
    if (w_start) w_busy_n[r_wr] = 1'b1;
    if (w_close) w_pend_n[r_wr] = 1'b1;
    if (w_done) begin
      w_busy_n[r_rd] = 1'b0;
      w_pend_n[r_rd] = 1'b0;
    end
  end

  always_comb begin
    w_state_n = r_state;
    txs_write = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_n = S_BURST;
      end
      S_BURST: begin
        txs_write = 1'b1;
        if (w_done) w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 2'b00;
      r_pend  <= 2'b00;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_cap   <= 1'b0;
      r_ready <= 1'b0;
      r_wbeat <= 3'd0;
      r_rbeat <= 3'd0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= w_busy_n;
      r_pend  <= w_pend_n;
      r_wr    <= w_wr_n;
      r_cap   <= w_cap_n;
      // Looks ahead so a slot freed this cycle is offered on the next.
      r_ready <= ~w_cap_n & ~w_busy_n[w_wr_n];
      if (w_take) r_wbeat <= w_widx + 3'd1;
      if (w_issue) r_rbeat <= 3'd0;
      else if (w_acc) r_rbeat <= r_rbeat + 3'd1;
      if (w_done) r_rd <= ~r_rd;
    end
  end

  // Zero-fill on the first word so an early-closed packet pads with zeros.
  always_ff @(posedge c) begin
    if (w_start) begin
      r_addr[r_wr] <= daddr;
      for (int k = 0; k < 8; k++) begin
        r_mem[r_wr][k] <= (k == 0) ? d : 128'h0;
      end
    end else if (dv & r_cap) begin
      r_mem[r_wr][r_wbeat] <= d;
    end
  end

  assign ready          = r_ready;
  assign txs_writedata  = r_mem[r_rd][r_rbeat];
  assign txs_address    = r_addr[r_rd];
  assign txs_burstcount = 6'd8;

endmodule

// File: tb/tb_dma_burst_writer.sv
// Directed bench for dma_burst_writer: expected beats queued by
// stimulus, popped and compared by a negedge bus monitor.
module tb_dma_burst_writer;

  logic         c = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] d = '0;
  logic         dv = 1'b0;
  logic         de = 1'b0;
  logic [22:0]  daddr = '0;
  logic         ready;
  logic         txs_write;
  logic [127:0] txs_writedata;
  logic [5:0]   txs_burstcount;
  logic [22:0]  txs_address;
  logic         txs_waitrequest = 1'b0;

  dma_burst_writer dut (
    .c               (c),
    .rst             (rst),
    .d               (d),
    .dv              (dv),
    .de              (de),
    .daddr           (daddr),
    .ready           (ready),
    .txs_write       (txs_write),
    .txs_writedata   (txs_writedata),
    .txs_burstcount  (txs_burstcount),
    .txs_address     (txs_address),
    .txs_waitrequest (txs_waitrequest)
  );

  always #5 c = ~c;

  typedef struct packed {
    logic [22:0]  a;
    logic [127:0] d;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int acc = 0;
  int mode = 0;
  int pi = 0;
  logic [4:0] pat = 5'b01101;

  // waitrequest: 0 = never, 1 = pattern 1,0,1,1,0..., 2 = always
  always @(posedge c) begin
    #2;
    case (mode)
      0: txs_waitrequest = 1'b0;
      1: begin
        txs_waitrequest = pat[pi % 5];
        pi++;
      end
      default: txs_waitrequest = 1'b1;
    endcase
  end

  logic         hold_v = 1'b0;
  logic [22:0]  hold_a;
  logic [127:0] hold_d;
  beat_t        e;

  always @(negedge c) begin
    if (rst) begin
      hold_v = 1'b0;
    end else if (txs_write) begin
      if (hold_v) begin
        checks++;
        if (txs_address !== hold_a || txs_writedata !== hold_d) begin
          errors++;
          $display("FAIL hold: got %h/%h want %h/%h",
                   txs_address, txs_writedata, hold_a, hold_d);
        end
      end
      if (!txs_waitrequest) begin
        hold_v = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h/%h want none",
                   txs_address, txs_writedata);
        end else begin
          e = exp_q.pop_front();
          if ({txs_address, txs_writedata, txs_burstcount} !==
              {e.a, e.d, 6'd8}) begin
            errors++;
            $display("FAIL beat: got %h/%h/%0d want %h/%h/8",
                     txs_address, txs_writedata, txs_burstcount, e.a, e.d);
          end
        end
        acc++;
      end else begin
        hold_v = 1'b1;
        hold_a = txs_address;
        hold_d = txs_writedata;
      end
    end else begin
      if (hold_v) begin
        checks++;
        errors++;
        $display("FAIL write_dropped: got 0 want 1");
      end
      hold_v = 1'b0;
    end
  end

  task automatic tick;
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [22:0] a, input int n,
                      input logic [127:0] base);
    int t;
    beat_t b;
    t = 0;
    while (!ready && t < 200) begin
      tick();
      t++;
    end
    chk("ready_wait", ready, 1);
    for (int i = 0; i < 8; i++) begin
      b.a = a;
      b.d = (i < n) ? base + 128'(i) : 128'h0;
      exp_q.push_back(b);
    end
    daddr = a;
    for (int i = 0; i < n; i++) begin
      dv = 1'b1;
      d  = base + 128'(i);
      de = (i == n - 1);
      tick();
    end
    dv = 1'b0;
    de = 1'b0;
    d  = '0;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 400) begin
      tick();
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  int a0;
  int tgt;
  int t;

  initial begin
    // 1: reset then idle
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_write", txs_write, 0);
      chk("rst_ready", ready, 0);
    end
    rst = 1'b0;
    tick();
    chk("ready_after_rst", ready, 1);
    chk("idle_write", txs_write, 0);

    // 2: single packet
    send(23'h10000, 8, 128'h1);
    drain();

    // 3: back-pressure pattern
    mode = 1;
    send(23'h20000, 8, 128'h200);
    drain();
    mode = 0;

    // 4: back-to-back under long stall
    mode = 2;
    a0 = acc;
    send(23'h10000, 8, 128'h100);
    send(23'h10080, 8, 128'h180);
    chk("ready_low_2nd", ready, 0);
    repeat (3) tick();
    chk("ready_still_low", ready, 0);
    chk("stall_no_accept", acc, a0);
    mode = 0;
    drain();
    chk("ready_back", ready, 1);

    // 5: early end-of-packet
    send(23'h30000, 3, 128'hA);
    drain();

    // 6: reset mid-burst
    send(23'h40000, 8, 128'h400);
    tgt = acc + 4;
    t = 0;
    while (acc < tgt && t < 200) begin
      tick();
      t++;
    end
    chk("beat4_reached", acc, tgt);
    rst  = 1'b1;
    mode = 2;
    tick();
    chk("write_after_rst", txs_write, 0);
    exp_q.delete();
    rst  = 1'b0;
    mode = 0;
    repeat (5) begin
      tick();
      chk("no_beats_after_rst", txs_write, 0);
    end
    send(23'h50000, 8, 128'h500);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
